// File: rtl/sccb_slave.sv
// SCCB slave with an 8-bit register pointer and a write-strobe register interface.
// Optional read support is enabled by defining SCCB_SLAVE_READ_EN. Without it,
// the read address is not acknowledged and RD_DATA is ignored.
`timescale 1ns/1ps

module sccb_slave #(
  parameter logic [7:0] DEV_ADDR = 8'h42
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCL,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic       WR_STB,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic [7:0] RD_ADDR,
  input  logic [7:0] RD_DATA,
  output logic [7:0] WR_CNT,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, REG, REG_ACK, DATA, DATA_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic        scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_prev_q, scl_prev_d;
  logic        sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_prev_q, sda_prev_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_stb_q, wr_stb_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic        busy_q, busy_d;

  logic        scl_rise, scl_fall, start_det, stop_det, byte_done, rx_state;

`ifdef SCCB_SLAVE_READ_EN
  logic        rd_dir_q, rd_dir_d;
  logic        mst_ack_q, mst_ack_d;
  logic [7:0]  rd_shift_q, rd_shift_d;
  logic [2:0]  rd_idx;
  assign rd_idx = 3'd7 - bit_cnt_q[2:0];
`else
  logic        unused_rd_data;
  assign unused_rd_data = ^RD_DATA;
`endif

  // Bus events are derived only from the synchronized copies and their previous values
  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign byte_done = (bit_cnt_q == 4'd8);
  assign rx_state  = (state_q == DEV) || (state_q == REG) || (state_q == DATA);

  assign SDA_OE  = sda_oe_q;
  assign WR_STB  = wr_stb_q;
  assign WR_ADDR = wr_addr_q;
  assign WR_DATA = wr_data_q;
  assign RD_ADDR = ptr_q;
  assign WR_CNT  = wr_cnt_q;
  assign BUSY    = busy_q;

  // Next-state and output logic; START/STOP override any bit processing
  always_comb begin
    scl_meta_d = SCL;
    scl_sync_d = scl_meta_q;
    scl_prev_d = scl_sync_q;
    sda_meta_d = SDA_IN;
    sda_sync_d = sda_meta_q;
    sda_prev_d = sda_sync_q;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_cnt_d   = wr_cnt_q;
    busy_d     = busy_q;
`ifdef SCCB_SLAVE_READ_EN
    rd_dir_d   = rd_dir_q;
    mst_ack_d  = mst_ack_q;
    rd_shift_d = rd_shift_q;
`endif

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = DEV;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      if (rx_state && scl_rise && !byte_done) begin
        shift_d   = {shift_q[6:0], sda_sync_q};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      unique case (state_q)
        IDLE: ;
        DEV: begin
          if (scl_fall && byte_done) begin
            if (shift_q == DEV_ADDR) begin
              state_d  = DEV_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
`ifdef SCCB_SLAVE_READ_EN
              rd_dir_d = 1'b0;
            end else if (shift_q == (DEV_ADDR | 8'h01)) begin
              state_d    = DEV_ACK;
              sda_oe_d   = 1'b1;
              busy_d     = 1'b1;
              rd_dir_d   = 1'b1;
              rd_shift_d = RD_DATA;
`endif
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        DEV_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            state_d   = REG;
            bit_cnt_d = 4'd0;
`ifdef SCCB_SLAVE_READ_EN
            if (rd_dir_q) begin
              state_d   = RD_BYTE;
              sda_oe_d  = ~rd_shift_q[7];
              bit_cnt_d = 4'd1;
            end
`endif
          end
        end
        REG: begin
          if (scl_fall && byte_done) begin
            ptr_d    = shift_q;
            state_d  = REG_ACK;
            sda_oe_d = 1'b1;
          end
        end
        REG_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            state_d   = DATA;
            bit_cnt_d = 4'd0;
          end
        end
        DATA: begin
          if (scl_fall && byte_done) begin
            state_d   = DATA_ACK;
            sda_oe_d  = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = shift_q;
            ptr_d     = ptr_q + 8'd1;
            wr_cnt_d  = wr_cnt_q + 8'd1;
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            state_d   = DATA;
            bit_cnt_d = 4'd0;
          end
        end
`ifdef SCCB_SLAVE_READ_EN
        RD_BYTE: begin
          if (scl_fall) begin
            if (byte_done) begin
              state_d  = RD_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d  = ~rd_shift_q[rd_idx];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            mst_ack_d = ~sda_sync_q;
            ptr_d     = ptr_q + 8'd1;
          end else if (scl_fall) begin
            if (mst_ack_q) begin
              state_d    = RD_BYTE;
              rd_shift_d = RD_DATA;
              sda_oe_d   = ~RD_DATA[7];
              bit_cnt_d  = 4'd1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
`endif
        IGNORE: sda_oe_d = 1'b0;
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; synchronizers reset to the idle bus level
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= 8'd0;
      sda_oe_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      wr_cnt_q   <= 8'd0;
      busy_q     <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
      rd_dir_q   <= 1'b0;
      mst_ack_q  <= 1'b0;
      rd_shift_q <= 8'd0;
`endif
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_cnt_q   <= wr_cnt_d;
      busy_q     <= busy_d;
`ifdef SCCB_SLAVE_READ_EN
      rd_dir_q   <= rd_dir_d;
      mst_ack_q  <= mst_ack_d;
      rd_shift_q <= rd_shift_d;
`endif
    end
  end

endmodule
